user_au_lpf_sched: RTL and testbench
====================================

// Module: user_au_lpf_sched
// PURPOSE
//  Time-multiplexed scheduler for a cascade of first-order audio low-pass stages.
//  Shares one combinational LPF datapath (y = x + ((decay*(prev-x)) >>> DECAY_FRAC))
//  across up to NUM_STAGES stages, one stage per cycle.
//  Holds per-stage history and decay registers; sits between the audio source and sink
//  on a valid/ready stream.
// PARAMETERS
//  NUM_STAGES   4    max cascade depth (>=1); sizes history/decay register files
//  DECAY_FRAC   10   fixed-point fraction bits of decay (1.0 = 1<<DECAY_FRAC)
//  DECAY_RESET  512  reset value of every stage decay register (0.5)
// PORTS
//  clk_i            in   1                   clock
//  rst_ni           in   1                   async reset, active-low
//  data_i           in   32                  signed input sample
//  valid_i          in   1                   input sample valid
//  ready_o          out  1                   scheduler can accept a sample
//  data_o           out  32                  signed filtered sample
//  valid_o          out  1                   output sample valid
//  ready_i          in   1                   sink accepts output
//  active_stages_i  in   $clog2(NUM_STAGES+1) stages to apply; sampled on input handshake
//  cfg_we_i         in   1                   decay register write strobe
//  cfg_idx_i        in   $clog2(NUM_STAGES)  stage index for write
//  cfg_decay_i      in   32                  signed decay value
//  cfg_ready_o      out  1                   write accepted this cycle (high only in IDLE)
//  clear_i          in   1                   sync flush: zero history, abort in-flight sample
//  busy_o           out  1                   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, history[*]=0, decay[*]=DECAY_RESET, acc=0, data_o=0,
//   valid_o=0, ready_o=1, cfg_ready_o=1, busy_o=0.
//  FSM IDLE -> COMPUTE -> OUTPUT -> IDLE.
//   IDLE:  ready_o=1; on valid_i: acc<=data_i, idx<=0, n<=min(active_stages_i,NUM_STAGES).
//          Go to OUTPUT if n==0 (pass-through), else go to COMPUTE.
//   COMPUTE: each cycle y=core(acc,history[idx],decay[idx]); acc<=y, history[idx]<=y, idx++;
//          leave for OUTPUT after stage n-1. ready_o=0.
//   OUTPUT: valid_o=1, data_o=acc; held stable while ready_i=0; on ready_i -> IDLE.
//  Latency: handshake edge at cycle 0 -> valid_o high from cycle n+1 (1 for n==0).
//  Throughput: one sample per n+2 cycles at full sink readiness; no input/output overlap.
//  Arithmetic: diff = prev-x in 32b (wraps); product = 64b signed decay*diff;
//   arithmetic shift right DECAY_FRAC (floor toward -inf); low 32b added to x, wraps mod 2^32.
//   No saturation.
//  Stages idx>=n are untouched (history preserved) for that sample.
//  Config: writes honoured only when cfg_we_i & cfg_ready_o (IDLE); otherwise dropped, no error.
//   A write in the same cycle as an input handshake is accepted and takes effect
//   from the next cycle, i.e. it applies to the sample just accepted.
//  clear_i (any state, priority over all): history[*]<=0, acc<=0, state<=IDLE next cycle.
//   An in-flight or unacknowledged output is discarded. Decay registers are kept.
//   Input handshake is ignored in a clear cycle.
//  Async reset mid-operation: immediate return to reset values; no output produced.
// STRUCTURE
//  Package user_au_lpf_pkg: sample_t (logic signed [31:0]), decay_t, DECAY_FRAC,
//   lpf_state_e {IDLE,COMPUTE,OUTPUT}.
//  Sub-module user_au_lpf_core: combinational y=f(x,prev,decay); the scheduler instantiates one.
//  History/decay storage: flop arrays (NUM_STAGES small), read by idx mux.
// TESTING
//  1 decay[0..1]=512, n=2, in 1024 then 1024 -> out 256, then 512; history ends {768,512}.
//  2 decay[0]=0, n=1, in -7 -> out -7; decay[0]=1024, n=1, in 5000 -> out -7 (held prev).
//  3 decay[0]=512, n=1, prev 0, in -1001 -> out -501 (floor shift); n=0, in 42 -> out 42 after 1 cycle.
//  4 ready_i low 5 cycles in OUTPUT -> data_o/valid_o stable, ready_o=0, cfg_we_i dropped (cfg_ready_o=0).
//  5 clear_i asserted mid-COMPUTE -> valid_o never rises for that sample; next in 1024,
//    decay 512, n=1 -> out 512.
//  6 rst_ni low during OUTPUT -> valid_o=0 immediately; decay back to 512, history 0.

Source files
------------

// File: rtl/user_au_lpf_pkg.sv
// Shared types and constants for the time-multiplexed audio low-pass scheduler.
//   sample_t    : signed 32-bit audio sample
//   decay_t     : signed 32-bit fixed-point decay (1.0 = 1 << DECAY_FRAC)
//   lpf_state_e : scheduler FSM states
package user_au_lpf_pkg;

    localparam int DECAY_FRAC = 10;

    typedef logic signed [31:0] sample_t;
    typedef logic signed [31:0] decay_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } lpf_state_e;

endpackage

// File: rtl/user_au_lpf_sched_if.sv
// Sample stream interface of the LPF scheduler. Signal names are from the
// scheduler's point of view.
//   data_i / valid_i / ready_o : sample source -> scheduler
//   data_o / valid_o / ready_i : scheduler -> sample sink
// Modports: slave = scheduler, master = source/sink environment.
interface user_au_lpf_sched_if;
    import user_au_lpf_pkg::*;

    sample_t data_i;
    logic    valid_i;
    logic    ready_o;
    sample_t data_o;
    logic    valid_o;
    logic    ready_i;

    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, data_o, valid_o
    );

    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o
    );

endinterface

// File: rtl/user_au_lpf_core.sv
// Combinational first-order low-pass step: y = x + ((decay * (prev - x)) >>> FRAC).
//   i_x     : stage input sample
//   i_prev  : stage history (previous output)
//   i_decay : stage decay coefficient
//   o_y     : stage output
// The difference wraps at 32 bits, the product is full 64-bit signed, the shift
// floors toward -inf, and the final add wraps; there is no saturation.
module user_au_lpf_core
    import user_au_lpf_pkg::*;
#(
    parameter int FRAC = DECAY_FRAC
) (
    input  sample_t i_x,
    input  sample_t i_prev,
    input  decay_t  i_decay,
    output sample_t o_y
);

    logic signed [31:0] w_diff;
    logic signed [63:0] w_prod;
    logic        [31:0] w_step;

    assign w_diff = i_prev - i_x;

    // Both operands are sign-extended by hand; the low 64 bits of the
    // unsigned product equal the two's-complement signed product.
    assign w_prod = {{32{i_decay[31]}}, i_decay} * {{32{w_diff[31]}}, w_diff};
    assign w_step = 32'(w_prod >>> FRAC);
    assign o_y    = i_x + $signed(w_step);

endmodule

// File: rtl/user_au_lpf_sched.sv
// Scheduler that applies up to NUM_STAGES cascaded first-order low-pass stages
// to each stream sample, sharing one LPF core, one stage per cycle.
//   clk_i, rst_ni     : clock, async active-low reset
//   strm              : sample stream (user_au_lpf_sched_if.slave)
//   active_stages_i   : stages to apply, sampled on the input handshake
//   cfg_we_i/idx/decay: decay register write, honoured only while IDLE
//   cfg_ready_o       : decay write accepted this cycle
//   clear_i           : flush history and any in-flight sample
//   busy_o            : scheduler not IDLE
//
// state   | meaning
// IDLE    | waiting for an input sample; config writes accepted
// COMPUTE | applying stage r_idx to r_acc, one stage per cycle
// OUTPUT  | presenting r_acc on data_o until the sink takes it
module user_au_lpf_sched #(
    parameter int NUM_STAGES  = 4,
    parameter int DECAY_FRAC  = user_au_lpf_pkg::DECAY_FRAC,
    parameter int DECAY_RESET = 512,
    localparam int CNT_W      = $clog2(NUM_STAGES + 1),
    localparam int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    user_au_lpf_sched_if.slave       strm,
    input  logic [CNT_W-1:0]         active_stages_i,
    input  logic                     cfg_we_i,
    input  logic [IDX_W-1:0]         cfg_idx_i,
    input  user_au_lpf_pkg::decay_t  cfg_decay_i,
    output logic                     cfg_ready_o,
    input  logic                     clear_i,
    output logic                     busy_o
);
    import user_au_lpf_pkg::*;

    lpf_state_e       r_state;
    lpf_state_e       w_state_nxt;
    sample_t          r_acc;
    sample_t          r_hist  [NUM_STAGES];
    decay_t           r_decay [NUM_STAGES];
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] w_n_in;
    logic [IDX_W-1:0] w_sel;
    logic             w_take;
    logic             w_last;
    logic             w_cfg_wr;
    sample_t          w_y;

    assign w_sel  = r_idx[IDX_W-1:0];
    assign w_n_in = (int'(active_stages_i) > NUM_STAGES) ? CNT_W'(NUM_STAGES) : active_stages_i;
    assign w_take = strm.valid_i && strm.ready_o;
    assign w_last = (r_idx == r_n - CNT_W'(1));

    user_au_lpf_core #(
        .FRAC    (DECAY_FRAC)
    ) u_core (
        .i_x     (r_acc),
        .i_prev  (r_hist[w_sel]),
        .i_decay (r_decay[w_sel]),
        .o_y     (w_y)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_take) w_state_nxt = (w_n_in == '0) ? OUTPUT : COMPUTE;
                COMPUTE: if (w_last) w_state_nxt = OUTPUT;
                OUTPUT:  if (strm.ready_i) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // ready_o and valid_o are masked during clear so that neither a sample
    // nor a discarded output can complete a handshake in that cycle.
    always_comb begin
        strm.ready_o = 1'b0;
        strm.valid_o = 1'b0;
        strm.data_o  = r_acc;
        cfg_ready_o  = 1'b0;
        busy_o       = 1'b1;
        case (r_state)
            IDLE: begin
                strm.ready_o = !clear_i;
                cfg_ready_o  = 1'b1;
                busy_o       = 1'b0;
            end
            OUTPUT:  strm.valid_o = !clear_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc <= '0;
            r_idx <= '0;
            r_n   <= '0;
            for (int i = 0; i < NUM_STAGES; i++) r_hist[i] <= '0;
        end else if (clear_i) begin
            r_acc <= '0;
            r_idx <= '0;
            r_n   <= '0;
            for (int i = 0; i < NUM_STAGES; i++) r_hist[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_acc <= strm.data_i;
                        r_idx <= '0;
                        r_n   <= w_n_in;
                    end
                end
                COMPUTE: begin
                    r_acc         <= w_y;
                    r_hist[w_sel] <= w_y;
                    r_idx         <= r_idx + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Decay registers survive clear; a write landing on the handshake edge
    // is already visible to the first COMPUTE cycle of that sample.
    assign w_cfg_wr = cfg_we_i && cfg_ready_o && (int'(cfg_idx_i) < NUM_STAGES);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_STAGES; i++) r_decay[i] <= decay_t'(DECAY_RESET);
        end else if (w_cfg_wr) begin
            r_decay[cfg_idx_i] <= cfg_decay_i;
        end
    end

endmodule

// File: tb/tb_user_au_lpf_sched.sv
// Self-checking bench for user_au_lpf_sched: directed scenarios followed by
// randomized traffic, checked by a scoreboard against a behavioural model.
module tb_user_au_lpf_sched;

    localparam int NS   = 4;
    localparam int FRAC = 10;

    logic               clk_i  = 1'b0;
    logic               rst_ni = 1'b0;
    logic [2:0]         active_stages_i;
    logic               cfg_we_i;
    logic [1:0]         cfg_idx_i;
    logic signed [31:0] cfg_decay_i;
    logic               cfg_ready_o;
    logic               clear_i;
    logic               busy_o;

    user_au_lpf_sched_if strm_if();

    user_au_lpf_sched #(
        .NUM_STAGES      (NS),
        .DECAY_FRAC      (FRAC),
        .DECAY_RESET     (512)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .strm            (strm_if),
        .active_stages_i (active_stages_i),
        .cfg_we_i        (cfg_we_i),
        .cfg_idx_i       (cfg_idx_i),
        .cfg_decay_i     (cfg_decay_i),
        .cfg_ready_o     (cfg_ready_o),
        .clear_i         (clear_i),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   m_hist  [NS];
    int   m_decay [NS];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    bit   seen      = 1'b0;
    bit   rand_sink = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired, got no event, required one (t=%0t)", nm, $time);
    endtask

    // Reference stage: prev-x wraps in 32 bits, product is exact, shift floors.
    function automatic int lpf(input int x, input int prev, input int d);
        int     diff;
        longint p;
        longint s;
        diff = prev - x;
        p    = longint'(d) * longint'(diff);
        s    = p >>> FRAC;
        return x + int'(s);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_hist[i]  = 0;
            m_decay[i] = 512;
        end
    endtask

    // Monitor: checks every output cycle against the queue head, including
    // first-appearance latency and stability while the sink stalls.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            seen = 1'b0;
        end else if (strm_if.valid_o) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got valid_o=1 data_o=%0d, required valid_o=0", strm_if.data_o);
            end else begin
                if (!seen) chk("latency_cycle", cyc, q[0].cyc);
                chk("data_o", strm_if.data_o, q[0].data);
                if (strm_if.ready_i) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end else begin
                    seen = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (rand_sink) strm_if.ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic cfg(input int idx, input int val);
        bit ok;
        ok = 1'b0;
        @(posedge clk_i);
        #1;
        cfg_we_i    = 1'b1;
        cfg_idx_i   = idx[1:0];
        cfg_decay_i = val;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_i);
            if (cfg_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) m_decay[idx] = val;
        else timeout("cfg_ready");
        @(posedge clk_i);
        #1;
        cfg_we_i = 1'b0;
    endtask

    task automatic send(input int x, input int act, input bit use_want = 1'b0, input int want = 0,
                        input bit with_cfg = 1'b0, input int cidx = 0, input int cval = 0);
        bit   ok;
        int   n;
        int   y;
        exp_t e;
        ok = 1'b0;
        @(posedge clk_i);
        #1;
        strm_if.data_i  = x;
        strm_if.valid_i = 1'b1;
        active_stages_i = act[2:0];
        if (with_cfg) begin
            cfg_we_i    = 1'b1;
            cfg_idx_i   = cidx[1:0];
            cfg_decay_i = cval;
        end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_i);
            if (strm_if.ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            timeout("input_ready");
        end else begin
            if (with_cfg) m_decay[cidx] = cval;
            n = (act > NS) ? NS : act;
            y = x;
            for (int s = 0; s < n; s++) begin
                y         = lpf(y, m_hist[s], m_decay[s]);
                m_hist[s] = y;
            end
            e.data = use_want ? want : y;
            e.cyc  = cyc + 1 + n;
            q.push_back(e);
        end
        @(posedge clk_i);
        #1;
        strm_if.valid_i = 1'b0;
        cfg_we_i        = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk_i);
            if (q.size() == 0 && !busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("drain_idle");
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_i);
            if (strm_if.valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("valid_rise");
    endtask

    task automatic do_clear();
        @(posedge clk_i);
        #1;
        clear_i = 1'b1;
        q.delete();
        for (int i = 0; i < NS; i++) m_hist[i] = 0;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        strm_if.data_i  = 0;
        strm_if.valid_i = 1'b0;
        strm_if.ready_i = 1'b1;
        active_stages_i = '0;
        cfg_we_i        = 1'b0;
        cfg_idx_i       = '0;
        cfg_decay_i     = 0;
        clear_i         = 1'b0;
        model_reset();

        #23;
        chk("rst_ready_o",     int'(strm_if.ready_o), 1);
        chk("rst_valid_o",     int'(strm_if.valid_o), 0);
        chk("rst_busy_o",      int'(busy_o), 0);
        chk("rst_cfg_ready_o", int'(cfg_ready_o), 1);
        chk("rst_data_o",      strm_if.data_o, 0);
        #4;
        rst_ni = 1'b1;

        // Two-stage cascade with reset decays.
        send(1024, 2, 1'b1, 256);
        send(1024, 2, 1'b1, 512);
        wait_idle();

        // Decay 0 passes x; decay 1.0 holds history.
        cfg(0, 0);
        send(-7, 1, 1'b1, -7);
        cfg(0, 1024);
        send(5000, 1, 1'b1, -7);
        wait_idle();

        // Clear during COMPUTE drops the sample and zeroes history.
        send(12345, 4);
        @(posedge clk_i);
        #1;
        clear_i = 1'b1;
        q.delete();
        for (int i = 0; i < NS; i++) m_hist[i] = 0;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        repeat (8) @(negedge clk_i);
        chk("clear_busy_o", int'(busy_o), 0);
        chk("clear_data_o", strm_if.data_o, 0);
        cfg(0, 512);
        send(1024, 1, 1'b1, 512);
        wait_idle();

        // Floor rounding on a negative product, then pass-through.
        do_clear();
        send(-1001, 1, 1'b1, -501);
        send(42, 0, 1'b1, 42);
        wait_idle();

        // Config write on the handshake edge applies to that sample.
        send(2048, 1, 1'b1, 2048, 1'b1, 0, 0);
        wait_idle();
        cfg(0, 512);

        // Sink stall in OUTPUT: output held, input blocked, config dropped.
        rand_sink       = 1'b0;
        strm_if.ready_i = 1'b0;
        send(100, 1);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i);
            #1;
            cfg_we_i    = 1'b1;
            cfg_idx_i   = 2'd0;
            cfg_decay_i = 7;
            @(negedge clk_i);
            chk("stall_ready_o",     int'(strm_if.ready_o), 0);
            chk("stall_cfg_ready_o", int'(cfg_ready_o), 0);
            chk("stall_valid_o",     int'(strm_if.valid_o), 1);
            chk("stall_busy_o",      int'(busy_o), 1);
        end
        @(posedge clk_i);
        #1;
        cfg_we_i        = 1'b0;
        strm_if.ready_i = 1'b1;
        wait_idle();
        send(1000, 1);
        wait_idle();

        // Async reset while an output is pending.
        strm_if.ready_i = 1'b0;
        cfg(1, 100);
        send(300, 2);
        wait_valid();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid_o",     int'(strm_if.valid_o), 0);
        chk("arst_busy_o",      int'(busy_o), 0);
        chk("arst_ready_o",     int'(strm_if.ready_o), 1);
        chk("arst_cfg_ready_o", int'(cfg_ready_o), 1);
        chk("arst_data_o",      strm_if.data_o, 0);
        q.delete();
        model_reset();
        @(negedge clk_i);
        #3;
        rst_ni          = 1'b1;
        strm_if.ready_i = 1'b1;
        send(1024, 2, 1'b1, 256);
        wait_idle();

        // Randomized traffic against the reference model.
        rand_sink = 1'b1;
        for (int i = 0; i < 250; i++) begin
            int x;
            int act;
            int d;
            bit wc;
            if ($urandom_range(0, 3) == 0) x = int'($urandom);
            else x = int'($urandom_range(0, 65535)) - 32768;
            act = int'($urandom_range(0, 7));
            wc  = ($urandom_range(0, 7) == 0);
            d   = int'($urandom_range(0, 2047)) - 512;
            if (!wc && $urandom_range(0, 9) == 0) cfg(int'($urandom_range(0, NS - 1)), d);
            send(x, act, 1'b0, 0, wc, int'($urandom_range(0, NS - 1)), d);
        end
        wait_idle();
        rand_sink = 1'b0;
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
